// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot sequencer that streams instruction words into CPU memory, then releases the CPU
//
// Optional feature macro: RUN_TIMEOUT_EN (bounds the RUN state to RUN_CYCLES cycles).
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   level, accepted only in IDLE; begins a load of prog_len words
//   prog_len  in   number of words to load, captured on start accept
//   in_valid  in   input word valid
//   in_data   in   instruction word
//   in_ready  out  high only in FETCH; word taken on in_valid & in_ready
//   stop      in   ends RUN
//   addrIn    out  instruction-memory byte address
//   dataTemp  out  instruction word
//   wrIn      out  one-cycle write strobe
//   go_contr  out  CPU run enable (high in RUN)
//   busy      out  high outside IDLE
//   done      out  one-cycle pulse in FIN
//   timeout   out  sticky run-budget expiry flag, cleared on start accept
module program_loader #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     CNT_W      = 16,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned     GO_DELAY   = 2,
    parameter int unsigned     RUN_CYCLES = 830
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] prog_len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stop,
    output logic [WIDTH-1:0] addrIn,
    output logic [WIDTH-1:0] dataTemp,
    output logic             wrIn,
    output logic             go_contr,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE, FETCH, SETUP, STROBE, HOLD, GAP, RUN, FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] addr_in_q, addr_in_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
    logic             in_ready_q, wr_q, go_q, busy_q, done_q;

`ifndef RUN_TIMEOUT_EN
    logic unused_run_cycles;
    assign unused_run_cycles = ^RUN_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        addr_in_d = addr_in_q;
        data_d    = data_q;
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = prog_len;
                    addr_d    = BASE_ADDR;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (prog_len == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                // in_ready_q is high throughout FETCH, so this is the handshake.
                if (in_valid && in_ready_q) begin
                    data_d    = in_data;
                    addr_in_d = addr_q;
                    state_d   = SETUP;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD: begin
                // Adding 4 keeps the low two address bits as they were in BASE_ADDR.
                addr_d = addr_q + WIDTH'(4);
                cnt_d  = cnt_q + CNT_W'(1);
                if ((cnt_q + CNT_W'(1)) == len_q) begin
                    tmr_d   = '0;
                    state_d = GAP;
                end else begin
                    state_d = FETCH;
                end
            end
            GAP: begin
                if (tmr_q == 32'(GO_DELAY - 1)) begin
                    tmr_d   = '0;
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            RUN: begin
`ifdef RUN_TIMEOUT_EN
                // Expiry wins the flag even when stop arrives in the same cycle.
                if (tmr_q == 32'(RUN_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                    if (stop) state_d = FIN;
                end
`else
                if (stop) state_d = FIN;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= BASE_ADDR;
            addr_in_q  <= BASE_ADDR;
            data_q     <= '0;
            tmr_q      <= '0;
            timeout_q  <= 1'b0;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            addr_in_q  <= addr_in_d;
            data_q     <= data_d;
            tmr_q      <= tmr_d;
            timeout_q  <= timeout_d;
            in_ready_q <= (state_d == FETCH);
            wr_q       <= (state_d == STROBE);
            go_q       <= (state_d == RUN);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == FIN);
        end
    end

    assign in_ready = in_ready_q;
    assign addrIn   = addr_in_q;
    assign dataTemp = data_q;
    assign wrIn     = wr_q;
    assign go_contr = go_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    localparam int GO_DELAY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] prog_len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        stop = 1'b0;
    logic [31:0] addrIn;
    logic [31:0] dataTemp;
    logic        wrIn;
    logic        go_contr;
    logic        busy;
    logic        done;
    logic        timeout;

    int total = 0;
    int passes = 0;

    always #5 clk = ~clk;

    program_loader #(
        .WIDTH(32), .CNT_W(16), .BASE_ADDR(32'h0), .GO_DELAY(GO_DELAY), .RUN_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .stop(stop),
        .addrIn(addrIn), .dataTemp(dataTemp), .wrIn(wrIn), .go_contr(go_contr),
        .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called right after a negedge with the DUT in IDLE; returns once go_contr is seen.
    task automatic do_load(input int n, input logic [31:0] w0, input int stall_idx,
                           input int stall_len, output int last_strobe, output int strobes);
        int idx = 0;
        int stall_left = stall_len;
        int go_cyc = -1;
        logic took = 1'b0;
        logic prev_wr = 1'b0;
        logic [31:0] prev_a = '0, prev_d = '0;
        strobes = 0;
        last_strobe = -1;
        prog_len = 16'(n);
        start    = 1'b1;
        in_valid = (stall_idx != 0);
        in_data  = w0;
        for (int cyc = 0; cyc < 300 && go_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (took) idx++;
            if (prev_wr) begin
                chk("hold_addr", addrIn, prev_a);
                chk("hold_data", dataTemp, prev_d);
            end
            prev_wr = wrIn;
            if (wrIn) begin
                chk("strobe_addr", addrIn, 32'(4 * strobes));
                chk("strobe_data", dataTemp, w0 + 32'(strobes));
                prev_a = 32'(4 * strobes);
                prev_d = w0 + 32'(strobes);
                strobes++;
                last_strobe = cyc;
            end
            if (go_contr) go_cyc = cyc;
            if (idx == stall_idx && stall_left > 0) begin
                in_valid = 1'b0;
                if (in_ready) stall_left--;
            end else begin
                in_valid = (idx < n);
            end
            in_data = w0 + 32'(idx);
            took = in_valid && in_ready;
        end
        in_valid = 1'b0;
        chk("go_seen", 32'(go_cyc >= 0), 32'd1);
        chk("go_delay", 32'(go_cyc - last_strobe), 32'(GO_DELAY + 2));
        chk("strobe_count", 32'(strobes), 32'(n));
    endtask

    initial begin
        int ls, ns, gocnt;

        // Reset state
        #1;
        chk("rst_wr", 32'(wrIn), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", addrIn, 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 0);

        // Test 1: reset in the middle of a strobe
        prog_len = 16'd2; start = 1'b1; in_valid = 1'b1; in_data = 32'h1111_2222;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10 && !wrIn; i++) @(negedge clk);
        chk("t1_strobe_reached", 32'(wrIn), 1);
        #2 reset = 1'b0;
        #1;
        chk("t1_wr_drop", 32'(wrIn), 0);
        chk("t1_busy_drop", 32'(busy), 0);
        chk("t1_go_drop", 32'(go_contr), 0);
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_addr", addrIn, 0);

        // Test 2: seven words, in_valid held high, 4 cycles per word
        do_load(7, 32'hC000_0001, -1, 0, ls, ns);
        chk("t2_last_strobe_cycle", 32'(ls), 32'(4 * 7 - 2));
        chk("t2_busy_run", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("t2_go_async_drop", 32'(go_contr), 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // Test 3: three words with a 5-cycle input stall before the second word
        do_load(3, 32'hA5A5_0010, 1, 5, ls, ns);
        chk("t3_last_strobe_cycle", 32'(ls), 32'(4 * 3 - 2 + 5));

        // Test 5: start ignored in RUN, then stop
        start = 1'b1; prog_len = 16'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_go_hold", 32'(go_contr), 1);
            chk("t5_no_ready", 32'(in_ready), 0);
        end
        start = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t5_go_low", 32'(go_contr), 0);
        chk("t5_done", 32'(done), 1);
        @(negedge clk);
        chk("t5_done_once", 32'(done), 0);
        chk("t5_idle", 32'(busy), 0);

        // Test 4: zero-length program
        prog_len = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_no_wr", 32'(wrIn), 0);
        chk("t4_no_go", 32'(go_contr), 0);
        @(negedge clk);
        chk("t4_done_end", 32'(done), 0);
        chk("t4_idle", 32'(busy), 0);

        // Test 6: run budget
        do_load(1, 32'h0000_BEEF, -1, 0, ls, ns);
        gocnt = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (go_contr) gocnt++;
            else break;
        end
`ifdef RUN_TIMEOUT_EN
        chk("t6_go_cycles", 32'(gocnt), 10);
        chk("t6_timeout", 32'(timeout), 1);
        chk("t6_done", 32'(done), 1);
        @(negedge clk);
        chk("t6_timeout_sticky", 32'(timeout), 1);
`else
        chk("t6_go_cycles", 32'(gocnt), 31);
        chk("t6_timeout", 32'(timeout), 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t6_done", 32'(done), 1);
        @(negedge clk);
`endif
        prog_len = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_timeout_clear", 32'(timeout), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
